kirsch_window_gen: RTL and testbench



---
 rtl/kirsch_pkg.sv | 38 +++
 rtl/kirsch_line_buf.sv | 40 ++++
 rtl/kirsch_window_gen.sv | 165 ++++++++++++++++
 tb/tb_kirsch_window_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kirsch_pkg.sv
// -----------------------------------------------------------------------------
// kirsch_pkg
// Shared types and constants for the Kirsch edge-detection slice.
//   PIX_W_DEF : default pixel width in bits
//   MIN_DIM   : smallest legal image width/height (a 3x3 window needs 3)
//   pix_t     : one pixel at the default width
//   win_t     : a full 3x3 neighbourhood p1..p9, shared by all kernel wrappers
// -----------------------------------------------------------------------------
package kirsch_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int MIN_DIM   = 3;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  // p1 p2 p3 = row r-2, p4 p5 p6 = row r-1, p7 p8 p9 = row r (p3/p6/p9 newest)
  typedef struct packed {
    pix_t p1;
    pix_t p2;
    pix_t p3;
    pix_t p4;
    pix_t p5;
    pix_t p6;
    pix_t p7;
    pix_t p8;
    pix_t p9;
  } win_t;

  // Pack nine taps into a window record in p1..p9 order.
  function automatic win_t make_win(input pix_t a, input pix_t b, input pix_t c,
                                    input pix_t d, input pix_t e, input pix_t f,
                                    input pix_t g, input pix_t h, input pix_t i);
    win_t w;
    w = '{p1: a, p2: b, p3: c, p4: d, p5: e, p6: f, p7: g, p8: h, p9: i};
    return w;
  endfunction

endpackage

// File: rtl/kirsch_line_buf.sv
// -----------------------------------------------------------------------------
// kirsch_line_buf
// One image line of pixel storage. A single address serves both read and
// write: the read is combinational and returns the value stored before this
// cycle's write, so chaining two instances moves a column up one line per
// accepted pixel.
//   clk      : clock, write on rising edge
//   i_addr   : column address
//   i_we     : write enable
//   i_wdata  : pixel to store at i_addr
//   o_rdata  : pixel currently stored at i_addr (pre-write value)
// Contents are intentionally not reset; rows that would read stale data never
// produce a window.
// -----------------------------------------------------------------------------
module kirsch_line_buf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic [AW-1:0]    i_addr,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  assign o_rdata = r_mem[i_addr];

  // Synchronous write of the addressed column.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else begin
      r_mem[i_addr] <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/kirsch_window_gen.sv
// -----------------------------------------------------------------------------
// kirsch_window_gen
// Streaming 3x3 window generator feeding the Kirsch directional kernels.
// Takes a raster pixel stream and emits one registered neighbourhood per
// interior pixel (row>=2, col>=2 of the newest pixel).
//   clk, rst_n             : clock, synchronous active-low reset
//   pix_in/pix_sof         : input pixel and start-of-frame flag
//   pix_valid/pix_ready    : input handshake
//   p1..p9                 : window taps (p1..p3 oldest row, p3/p6/p9 newest col)
//   win_valid/win_ready    : output handshake
//   frame_done             : one-cycle pulse after the last window is consumed
// -----------------------------------------------------------------------------
module kirsch_window_gen
  import kirsch_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_sof,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic [PIX_W-1:0] p9,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [PIX_W-1:0] r_tap [1:9];
  logic             r_win_valid;
  logic             r_last_win;   // output stage holds the frame's final window
  logic             r_frame_done;

  logic             w_accept;
  logic             w_consume;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_win;
  logic [PIX_W-1:0] w_top;
  logic [PIX_W-1:0] w_mid;

  // Single output stage: a new window may enter when the slot is empty or
  // is being drained this cycle.
  assign pix_ready = !r_win_valid || win_ready;
  assign w_accept  = pix_valid && pix_ready;
  assign w_consume = r_win_valid && win_ready;

  // Start-of-frame overrides the counters so a stream can resync anywhere.
  assign w_col      = pix_sof ? '0 : r_col;
  assign w_row      = pix_sof ? '0 : r_row;
  assign w_col_last = (w_col == COL_W'(IMG_W - 1));
  assign w_row_last = (w_row == ROW_W'(IMG_H - 1));
  assign w_win      = (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));

  // LB0 holds row r-1, LB1 holds row r-2; LB1 is refilled from LB0's old value.
  kirsch_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) u_lb0 (
    .clk     (clk),
    .i_addr  (w_col),
    .i_we    (w_accept),
    .i_wdata (pix_in),
    .o_rdata (w_mid)
  );

  kirsch_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) u_lb1 (
    .clk     (clk),
    .i_addr  (w_col),
    .i_we    (w_accept),
    .i_wdata (w_mid),
    .o_rdata (w_top)
  );

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : (w_row + ROW_W'(1));
      end else begin
        r_col <= w_col + COL_W'(1);
        r_row <= w_row;
      end
    end else begin
      r_col <= r_col;
      r_row <= r_row;
    end
  end

  // Window shift registers: each accept shifts one new column in on the right.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i <= 9; i++) begin
        r_tap[i] <= '0;
      end
    end else if (w_accept) begin
      r_tap[1] <= r_tap[2];
      r_tap[2] <= r_tap[3];
      r_tap[3] <= w_top;
      r_tap[4] <= r_tap[5];
      r_tap[5] <= r_tap[6];
      r_tap[6] <= w_mid;
      r_tap[7] <= r_tap[8];
      r_tap[8] <= r_tap[9];
      r_tap[9] <= pix_in;
    end else begin
      for (int i = 1; i <= 9; i++) begin
        r_tap[i] <= r_tap[i];
      end
    end
  end

  // Output valid, last-window tracking and the frame_done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_valid  <= 1'b0;
      r_last_win   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_win_valid <= w_win;
        r_last_win  <= w_win && w_row_last && w_col_last;
      end else if (w_consume) begin
        r_win_valid <= 1'b0;
        r_last_win  <= 1'b0;
      end else begin
        r_win_valid <= r_win_valid;
        r_last_win  <= r_last_win;
      end
      r_frame_done <= w_consume && r_last_win;
    end
  end

  assign p1         = r_tap[1];
  assign p2         = r_tap[2];
  assign p3         = r_tap[3];
  assign p4         = r_tap[4];
  assign p5         = r_tap[5];
  assign p6         = r_tap[6];
  assign p7         = r_tap[7];
  assign p8         = r_tap[8];
  assign p9         = r_tap[9];
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_kirsch_window_gen.sv
// -----------------------------------------------------------------------------
// tb_kirsch_window_gen
// Self-checking bench for kirsch_window_gen on a 5x5 image. A reference model
// stores each received frame as a 2D image and derives every expected 3x3
// window directly from image coordinates.
// -----------------------------------------------------------------------------
module tb_kirsch_window_gen;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic          pix_sof = 1'b0;
  logic          pix_valid = 1'b0;
  logic          win_ready = 1'b1;
  logic          pix_ready;
  logic          win_valid;
  logic          frame_done;
  logic [PW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;

  always #5 clk = ~clk;

  kirsch_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_sof    (pix_sof),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .p4         (p4),
    .p5         (p5),
    .p6         (p6),
    .p7         (p7),
    .p8         (p8),
    .p9         (p9),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [71:0] w;
    logic        last;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  bit          rand_gap = 1'b0;
  exp_t        exp_q[$];
  logic [71:0] log_q[$];
  logic [71:0] s1_log[$];
  logic [7:0]  img [0:H-1][0:W-1];
  int          m_row = 0;
  int          m_col = 0;
  bit          exp_fd = 1'b0;
  bit          hold_v = 1'b0;
  logic [71:0] hold_w = '0;
  wire  [71:0] obs_w = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

  function automatic logic [71:0] mk(input int a, input int b, input int c,
                                     input int d, input int e, input int f,
                                     input int g, input int h, input int i);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model and per-cycle checks, evaluated between active edges.
  always @(negedge clk) begin
    bit          acc;
    bit          cons;
    bit          popped_last;
    exp_t        e;
    logic [71:0] wv;
    acc         = pix_valid && pix_ready;
    cons        = win_valid && win_ready;
    popped_last = 1'b0;
    chk("pix_ready", 72'(pix_ready), 72'(!win_valid || win_ready));
    chk("frame_done", 72'(frame_done), 72'(exp_fd));
    chk("win_valid", 72'(win_valid), 72'(exp_q.size() != 0));
    if (frame_done) fd_cnt++;
    if (hold_v) begin
      chk("hold_valid", 72'(win_valid), 72'(1));
      chk("hold_taps", obs_w, hold_w);
    end
    if (cons && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      popped_last = e.last;
      chk("window", obs_w, e.w);
    end
    if (cons) log_q.push_back(obs_w);
    if (!rst_n) begin
      exp_q.delete();
      m_row  = 0;
      m_col  = 0;
      exp_fd = 1'b0;
      hold_v = 1'b0;
    end else begin
      exp_fd = cons && popped_last;
      hold_v = win_valid && !win_ready;
      hold_w = obs_w;
      if (acc) begin
        if (pix_sof) begin
          m_row = 0;
          m_col = 0;
        end
        img[m_row][m_col] = pix_in;
        if (m_row >= 2 && m_col >= 2) begin
          wv = '0;
          for (int dr = 2; dr >= 0; dr--)
            for (int dc = 2; dc >= 0; dc--)
              wv = {wv[63:0], img[m_row-dr][m_col-dc]};
          e.w    = wv;
          e.last = (m_row == H-1) && (m_col == W-1);
          exp_q.push_back(e);
        end
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row++;
          if (m_row == H) m_row = 0;
        end
      end
    end
  end

  task automatic send_px(input int v, input bit sof);
    bit ok;
    int n;
    if (rand_gap && ($urandom_range(1, 0) == 1)) begin
      pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    pix_in    = 8'(v);
    pix_sof   = sof;
    pix_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = pix_ready;
      @(posedge clk); #1;
      n++;
    end
    chk("accept_in_time", 72'(ok), 72'(1));
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic new_scenario();
    log_q.delete();
    fd_cnt = 0;
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    chk("reset_taps", obs_w, 72'(0));
    chk("reset_win_valid", 72'(win_valid), 72'(0));
    chk("reset_frame_done", 72'(frame_done), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: plain 5x5 frame, continuous valid
    new_scenario();
    for (int i = 0; i < 25; i++) send_px(i, i == 0);
    idle(4);
    chk("s1_count", 72'(log_q.size()), 72'(9));
    if (log_q.size() == 9) begin
      chk("s1_first", log_q[0], mk(0, 1, 2, 5, 6, 7, 10, 11, 12));
      chk("s1_last", log_q[8], mk(12, 13, 14, 17, 18, 19, 22, 23, 24));
    end
    chk("s1_frame_done", 72'(fd_cnt), 72'(1));
    s1_log = log_q;

    // 2: downstream stall at the second window
    new_scenario();
    for (int i = 0; i < 14; i++) send_px(i, i == 0);
    win_ready = 1'b0;
    pix_in    = 8'd14;
    pix_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("s2_stall_ready", 72'(pix_ready), 72'(0));
      chk("s2_stall_win", obs_w, mk(1, 2, 3, 6, 7, 8, 11, 12, 13));
      @(posedge clk); #1;
    end
    win_ready = 1'b1;
    for (int i = 14; i < 25; i++) send_px(i, 1'b0);
    idle(4);
    chk("s2_count", 72'(log_q.size()), 72'(9));
    if (log_q.size() >= 2) chk("s2_win2", log_q[1], mk(1, 2, 3, 6, 7, 8, 11, 12, 13));
    chk("s2_frame_done", 72'(fd_cnt), 72'(1));

    // 3: random input gaps give the same window sequence as scenario 1
    new_scenario();
    rand_gap = 1'b1;
    for (int i = 0; i < 25; i++) send_px(i, i == 0);
    rand_gap = 1'b0;
    idle(4);
    chk("s3_count", 72'(log_q.size()), 72'(9));
    for (int i = 0; i < 9; i++)
      if (i < log_q.size() && i < s1_log.size()) chk("s3_same", log_q[i], s1_log[i]);
    chk("s3_frame_done", 72'(fd_cnt), 72'(1));

    // 4: reset mid-frame, then a fresh frame without sof
    for (int i = 0; i < 18; i++) send_px(i, i == 0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("s4_rst_taps", obs_w, 72'(0));
    chk("s4_rst_valid", 72'(win_valid), 72'(0));
    new_scenario();
    for (int i = 100; i < 112; i++) send_px(i, 1'b0);
    chk("s4_none_before_112", 72'(log_q.size() + int'(win_valid)), 72'(0));
    for (int i = 112; i < 125; i++) send_px(i, 1'b0);
    idle(4);
    chk("s4_count", 72'(log_q.size()), 72'(9));
    if (log_q.size() > 0) chk("s4_first", log_q[0], mk(100, 101, 102, 105, 106, 107, 110, 111, 112));
    chk("s4_frame_done", 72'(fd_cnt), 72'(1));

    // 5: sof mid-frame resynchronises the counters
    new_scenario();
    for (int i = 0; i < 7; i++) send_px(i, i == 0);
    for (int i = 7; i < 32; i++) send_px(i, i == 7);
    idle(4);
    chk("s5_count", 72'(log_q.size()), 72'(9));
    if (log_q.size() > 0) chk("s5_first", log_q[0], mk(7, 8, 9, 12, 13, 14, 17, 18, 19));
    chk("s5_frame_done", 72'(fd_cnt), 72'(1));

    // 6: two back-to-back frames
    new_scenario();
    for (int i = 0; i < 25; i++) send_px(i, i == 0);
    for (int i = 200; i < 225; i++) send_px(i, i == 200);
    idle(4);
    chk("s6_count", 72'(log_q.size()), 72'(18));
    if (log_q.size() == 18) begin
      chk("s6_f2_first", log_q[9], mk(200, 201, 202, 205, 206, 207, 210, 211, 212));
      chk("s6_f2_last", log_q[17], mk(212, 213, 214, 217, 218, 219, 222, 223, 224));
    end
    chk("s6_frame_done", 72'(fd_cnt), 72'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
